freddy_list_ckpt: RTL

- Parametrised free-list / ready-list for the R10K rename stage; successor of the single-snapshot free list.
- Allocates up to N physical registers per cycle internally via a priority encoder. Frees retiring T_old registers and marks completing T_new registers ready.
- Holds NUM_CKPT internal branch checkpoints. Each checkpoint has a tag, is released on correct resolution, and is restored on mispredict. A restore squashes all younger checkpoints.
- Sits between dispatch/rename, retire, complete, and the branch stack.

---
 rtl/freddy_list_ckpt.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/freddy_list_ckpt.sv
// Free-list / ready-list for the R10K rename stage with NUM_CKPT tagged branch
// checkpoints; younger checkpoints are tracked through a dependency matrix.
module freddy_list_ckpt #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int N        = 3,
  parameter int NUM_CKPT = 4,
  parameter int IDX_W    = $clog2(NUM_PHYS),
  parameter int CNT_W    = $clog2(NUM_PHYS + 1),
  parameter int TAG_W    = $clog2(NUM_CKPT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [$clog2(N+1)-1:0]  alloc_num,
  output logic                    alloc_ok,
  output logic [N*IDX_W-1:0]      alloc_idx,
  output logic [CNT_W-1:0]        free_count,
  input  logic [N-1:0]            retire_valid,
  input  logic [N*IDX_W-1:0]      retire_idx,
  input  logic [N-1:0]            complete_valid,
  input  logic [N*IDX_W-1:0]      complete_idx,
  input  logic                    ckpt_save,
  output logic [TAG_W-1:0]        ckpt_save_tag,
  output logic                    ckpt_full,
  input  logic                    ckpt_release,
  input  logic [TAG_W-1:0]        ckpt_release_tag,
  input  logic                    restore,
  input  logic [TAG_W-1:0]        restore_tag,
  output logic [NUM_PHYS-1:0]     free_list,
  output logic [NUM_PHYS-1:0]     ready_list,
  output logic [NUM_CKPT-1:0]     ckpt_valid
);

  logic [NUM_PHYS-1:0] free_list_reg, free_list_next;
  logic [NUM_PHYS-1:0] ready_list_reg, ready_list_next;
  logic [NUM_CKPT-1:0] ckpt_valid_reg, ckpt_valid_next;
  logic [NUM_PHYS-1:0] ckpt_mem_reg [NUM_CKPT];
  logic [NUM_PHYS-1:0] ckpt_mem_next [NUM_CKPT];
  logic [NUM_CKPT-1:0] dep_reg [NUM_CKPT];
  logic [NUM_CKPT-1:0] dep_next [NUM_CKPT];
  logic [NUM_PHYS-1:0] alloc_mask, retire_mask, complete_mask;
  logic [NUM_CKPT-1:0] kill_mask, save_onehot;
  logic                alloc_fire, save_fire;

  assign free_list  = free_list_reg;
  assign ready_list = ready_list_reg;
  assign ckpt_valid = ckpt_valid_reg;

  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_PHYS; i++) begin
      free_count = free_count + CNT_W'(free_list_reg[i]);
    end
  end

  // Slot k picks the k-th lowest free register; slots beyond free_count read 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    logic [IDX_W-1:0] sel;
    int               seen;
    always_comb begin
      sel  = '0;
      seen = 0;
      for (int i = 0; i < NUM_PHYS; i++) begin
        if (free_list_reg[i]) begin
          if (seen == gi) sel = IDX_W'(i);
          seen = seen + 1;
        end
      end
    end
    assign alloc_idx[gi*IDX_W +: IDX_W] = sel;
  end

  assign alloc_ok   = (free_count >= CNT_W'(alloc_num)) && !restore;
  assign alloc_fire = (alloc_num != '0) && alloc_ok;
  assign ckpt_full  = &ckpt_valid_reg;
  assign save_fire  = ckpt_save && !restore && !ckpt_full;

  always_comb begin
    alloc_mask    = '0;
    retire_mask   = '0;
    complete_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (alloc_fire && (k < int'(alloc_num))) alloc_mask[alloc_idx[k*IDX_W +: IDX_W]] = 1'b1;
      if (retire_valid[k])   retire_mask[retire_idx[k*IDX_W +: IDX_W]]     = 1'b1;
      if (complete_valid[k]) complete_mask[complete_idx[k*IDX_W +: IDX_W]] = 1'b1;
    end
  end

  always_comb begin
    ckpt_save_tag = '0;
    for (int v = NUM_CKPT - 1; v >= 0; v--) begin
      if (!ckpt_valid_reg[v]) ckpt_save_tag = TAG_W'(v);
    end
  end

  // Retires are never forwarded into this cycle's allocation; they land on the edge.
  always_comb begin
    if (restore) free_list_next = ckpt_mem_reg[restore_tag] | retire_mask;
    else         free_list_next = (free_list_reg & ~alloc_mask) | retire_mask;
    ready_list_next = (ready_list_reg & ~alloc_mask) | complete_mask;
  end

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_ckpt
    assign save_onehot[gi] = save_fire && (ckpt_save_tag == TAG_W'(gi));
    assign kill_mask[gi]   = (restore && ((restore_tag == TAG_W'(gi)) || dep_reg[restore_tag][gi]))
                           || (ckpt_release && (ckpt_release_tag == TAG_W'(gi)));
    assign ckpt_valid_next[gi] = save_onehot[gi] | (ckpt_valid_reg[gi] & ~kill_mask[gi]);
    assign ckpt_mem_next[gi]   = save_onehot[gi]    ? free_list_next :
                                 ckpt_valid_reg[gi] ? (ckpt_mem_reg[gi] | retire_mask) :
                                                      ckpt_mem_reg[gi];
    // dep[v][w] means w is younger than v; a new save becomes younger than every live slot.
    for (genvar gj = 0; gj < NUM_CKPT; gj++) begin : g_dep
      assign dep_next[gi][gj] = save_onehot[gj] ? (ckpt_valid_reg[gi] & ~kill_mask[gi]) :
                                save_onehot[gi] ? 1'b0 :
                                (dep_reg[gi][gj] & ~kill_mask[gi] & ~kill_mask[gj]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_list_reg  <= {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
      ready_list_reg <= {{(NUM_PHYS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
      ckpt_valid_reg <= '0;
      for (int v = 0; v < NUM_CKPT; v++) begin
        ckpt_mem_reg[v] <= '0;
        dep_reg[v]      <= '0;
      end
    end else begin
      free_list_reg  <= free_list_next;
      ready_list_reg <= ready_list_next;
      ckpt_valid_reg <= ckpt_valid_next;
      for (int v = 0; v < NUM_CKPT; v++) begin
        ckpt_mem_reg[v] <= ckpt_mem_next[v];
        dep_reg[v]      <= dep_next[v];
      end
    end
  end

  a_save_full: assert property (@(posedge clock) disable iff (!reset)
    !(ckpt_save && ckpt_full && !restore))
    else $warning("ckpt_save ignored: all checkpoint slots are valid");

  a_restore_valid: assert property (@(posedge clock) disable iff (!reset)
    restore |-> ckpt_valid_reg[restore_tag]);

endmodule
